// File: rtl/div_32_seq.sv
// ============================================================================
// div_32_seq -- sequential 32-bit restoring divider for the Mini-SRC DIV
// instruction, plus the add_32 carry-lookahead adder that performs its trial
// subtraction.
//
// One quotient bit is produced per clock:
//   IDLE (start) -> 32 CALC cycles -> 1 FIX cycle -> IDLE with done pulsed.
// The quotient is written to lo and the remainder to hi. Both are held, along
// with dbz, until the next completion.
//
// Ports (div_32_seq):
//   clk       in   rising-edge clock
//   clr       in   synchronous active-high reset
//   start     in   request, only looked at while IDLE
//   dividend  in   [31:0] numerator, captured when start is accepted
//   divisor   in   [31:0] denominator, captured when start is accepted
//   busy      out  high while in CALC or FIX
//   done      out  one-cycle pulse after the results are written
//   lo        out  [31:0] quotient
//   hi        out  [31:0] remainder
//   dbz       out  divide-by-zero flag of the last completed operation
//
// Configuration macro: DIV_SIGNED_EN
//   defined   -> two's-complement operands. The quotient truncates toward zero
//                and the remainder takes the sign of the dividend.
//   undefined -> unsigned operands with no magnitude or negate logic.
// ============================================================================

// ----------------------------------------------------------------------------
// add_32 -- 32-bit adder built from eight 4-bit carry-lookahead groups. The
// carry ripples between groups.
//   a_i, b_i  in   [31:0] addends
//   cin_i     in   carry in
//   sum_o     out  [31:0] sum
//   cout_o    out  carry out
// ----------------------------------------------------------------------------
module add_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] gen;
    logic [31:0] prop;
    logic [32:0] carry;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Each group resolves its four internal carries directly from the group's
    // carry-in, so the delay inside a group is flat.
    always_comb begin
        carry    = '0;
        carry[0] = cin_i;
        for (int grp = 0; grp < 8; grp++) begin
            carry[4*grp+1] = gen[4*grp]
                           | (prop[4*grp] & carry[4*grp]);
            carry[4*grp+2] = gen[4*grp+1]
                           | (prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+1] & prop[4*grp] & carry[4*grp]);
            carry[4*grp+3] = gen[4*grp+2]
                           | (prop[4*grp+2] & gen[4*grp+1])
                           | (prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+2] & prop[4*grp+1] & prop[4*grp] & carry[4*grp]);
            carry[4*grp+4] = gen[4*grp+3]
                           | (prop[4*grp+3] & gen[4*grp+2])
                           | (prop[4*grp+3] & prop[4*grp+2] & gen[4*grp+1])
                           | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & gen[4*grp])
                           | (prop[4*grp+3] & prop[4*grp+2] & prop[4*grp+1] & prop[4*grp] & carry[4*grp]);
        end
    end

    assign sum_o  = prop ^ carry[31:0];
    assign cout_o = carry[32];

endmodule

// ----------------------------------------------------------------------------
// div_32_seq -- top level of the divider
// ----------------------------------------------------------------------------
module div_32_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        dbz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [31:0] partRem_q, partRem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        dbz_q, dbz_d;
    logic        dbzRun_q, dbzRun_d;
    logic        done_q, done_d;

    logic [31:0] dividendMag;
    logic [31:0] divisorMag;
    logic [31:0] quoFix;
    logic [31:0] remFix;
    logic [31:0] remShift;
    logic [31:0] trialDiff;
    logic        trialCout;
    logic        noBorrow;

`ifdef DIV_SIGNED_EN
    logic signQ_q;
    logic signR_q;

    // The result signs are captured together with the operands. They are
    // only loaded when a start is accepted.
    always_ff @(posedge clk) begin
        if (clr) begin
            signQ_q <= 1'b0;
            signR_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            signQ_q <= dividend[31] ^ divisor[31];
            signR_q <= dividend[31];
        end
    end

    assign dividendMag = dividend[31] ? (32'd0 - dividend) : dividend;
    assign divisorMag  = divisor[31]  ? (32'd0 - divisor)  : divisor;

    // On a divide by zero the all-ones quotient is passed through unsigned.
    // The remainder is still re-signed, which reproduces the dividend exactly
    // as it was captured.
    assign quoFix = (signQ_q && !dbzRun_q) ? (32'd0 - quo_q) : quo_q;
    assign remFix = signR_q ? (32'd0 - partRem_q) : partRem_q;
`else
    assign dividendMag = dividend;
    assign divisorMag  = divisor;
    assign quoFix      = quo_q;
    assign remFix      = partRem_q;
`endif

    // The next dividend bit moves from the top of Q into the bottom of R.
    assign remShift = {partRem_q[30:0], quo_q[31]};

    // The trial subtraction is R_shifted + ~D + 1.
    add_32 trialSub (
        .a_i    (remShift),
        .b_i    (~dvsr_q),
        .cin_i  (1'b1),
        .sum_o  (trialDiff),
        .cout_o (trialCout)
    );

    // The shifted remainder is really 33 bits wide. If the bit shifted out of
    // R was set, the value is at least 2^32 and always exceeds the divisor,
    // even when the 32-bit subtraction reports a borrow.
    assign noBorrow = trialCout | partRem_q[31];

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. CALC exits after the iteration in which the counter
    // reads 31, which gives exactly 32 iterations.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (count_q == 5'd31) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic. busy decodes directly from the state. The
    // datapath registers update only in the state that owns them.
    always_comb begin
        busy      = (state_q != IDLE);
        partRem_d = partRem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        count_d   = count_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        dbz_d     = dbz_q;
        dbzRun_d  = dbzRun_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    partRem_d = '0;
                    quo_d     = dividendMag;
                    dvsr_d    = divisorMag;
                    count_d   = '0;
                    dbzRun_d  = (divisor == 32'd0);
                end
            end
            CALC: begin
                partRem_d = noBorrow ? trialDiff : remShift;
                quo_d     = {quo_q[30:0], noBorrow};
                count_d   = count_q + 5'd1;
            end
            FIX: begin
                lo_d   = quoFix;
                hi_d   = remFix;
                dbz_d  = dbzRun_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers. A clear aborts any operation in flight and wipes the
    // visible results.
    always_ff @(posedge clk) begin
        if (clr) begin
            partRem_q <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            count_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            dbz_q     <= 1'b0;
            dbzRun_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            partRem_q <= partRem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            count_q   <= count_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            dbz_q     <= dbz_d;
            dbzRun_q  <= dbzRun_d;
            done_q    <= done_d;
        end
    end

    assign done = done_q;
    assign lo   = lo_q;
    assign hi   = hi_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_32_seq.sv
// ============================================================================
// tb_div_32_seq -- self-checking bench for div_32_seq.
// It applies a table of directed vectors, then hand-written handshake and
// reset sequences, then random operands checked against an arithmetic
// reference model. It follows DIV_SIGNED_EN in the same way as the design.
// ============================================================================
module tb_div_32_seq;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } vec_t;

    vec_t vecs[$];

    div_32_seq dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .lo       (lo),
        .hi       (hi),
        .dbz      (dbz)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // This model works from the arithmetic definition of the result, not from
    // the shift-subtract algorithm.
    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r,
                                     output logic z);
        longint sa, sb, sq, sr;
        z = (b == 32'd0);
        if (z) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
`else
            sa = {32'd0, a};
            sb = {32'd0, b};
`endif
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end
    endfunction

    // Compare one value and record the result
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Start one operation and wait at most 60 edges for done. An edge number
    // in intrudeEdge makes the bench raise start there with other operands.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input int intrudeEdge,
                                 output int latency, output logic busyOk);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        busyOk  = busy;
        latency = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == intrudeEdge - 1) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd3;
            end else if (k == intrudeEdge) begin
                start = 1'b0;
            end
            if (done) begin
                latency = k;
                break;
            end
            if (!busy) busyOk = 1'b0;
        end
    endtask

    // Run one complete operation and check everything it produces
    task automatic runVector(input string name, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expLo,
                             input logic [31:0] expHi, input logic expDbz,
                             input int intrudeEdge);
        int   latency;
        logic busyOk;
        applyStimulus(a, b, intrudeEdge, latency, busyOk);
        checkOutput({name, " latency"}, 32'(latency), 32'd33);
        checkOutput({name, " busy"}, {31'd0, busyOk}, 32'd1);
        checkOutput({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
        checkOutput({name, " lo"}, lo, expLo);
        checkOutput({name, " hi"}, hi, expHi);
        checkOutput({name, " dbz"}, {31'd0, dbz}, {31'd0, expDbz});
        @(posedge clk);
        #1;
        checkOutput({name, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] q, r, a, b;
        logic        z;
        int          firstDone, secondDone, doneSeen;

        vectors     = 0;
        miscompares = 0;
        clr         = 1'b1;
        start       = 1'b0;
        dividend    = '0;
        divisor     = '0;

        // Directed vectors
        vecs.push_back('{32'd100,   32'd7, 32'd14,        32'd2,     1'b0});
        vecs.push_back('{32'd12345, 32'd0, 32'hFFFFFFFF,  32'd12345, 1'b1});
        vecs.push_back('{32'd10,    32'd5, 32'd2,         32'd0,     1'b0});
        vecs.push_back('{32'd5,     32'd9, 32'd0,         32'd5,     1'b0});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0});
        vecs.push_back('{32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1});
`else
        vecs.push_back('{32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'd1,        1'b0});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1,        1'b0});
        vecs.push_back('{32'h80000005, 32'd0,        32'hFFFFFFFF, 32'h80000005, 1'b1});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset lo", lo, 32'd0);
        checkOutput("reset hi", hi, 32'd0);
        checkOutput("reset dbz", {31'd0, dbz}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        foreach (vecs[i]) begin
            runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                      vecs[i].lo, vecs[i].hi, vecs[i].dbz, 0);
        end

        // Results hold while idle
        repeat (5) @(posedge clk);
        #1;
        checkOutput("hold lo", lo, vecs[vecs.size()-1].lo);
        checkOutput("hold hi", hi, vecs[vecs.size()-1].hi);

        // A start at E10 with new operands is ignored
        runVector("ignore_start", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10);

        // Holding start high gives back-to-back operations
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        firstDone  = -1;
        secondDone = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (firstDone < 0) begin
                    firstDone = k;
                end else begin
                    secondDone = k;
                    break;
                end
            end
        end
        start = 1'b0;
        checkOutput("b2b first_done", 32'(firstDone), 32'd33);
        checkOutput("b2b spacing", 32'(secondDone - firstDone), 32'd34);
        checkOutput("b2b lo", lo, 32'd14);
        repeat (2) @(posedge clk);

        // A clear at E15 aborts the operation
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("clr busy", {31'd0, busy}, 32'd0);
        checkOutput("clr lo", lo, 32'd0);
        checkOutput("clr hi", hi, 32'd0);
        @(negedge clk);
        clr      = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("clr no_done", 32'(doneSeen), 32'd0);
        runVector("after_clr", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 0);

        // Random operands against the reference model
        for (int n = 0; n < 40; n++) begin
            int sel;
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 32'd0;
            else if (sel < 5)  b = $urandom_range(1, 255);
            else if (sel == 5) b = 32'd0 - $urandom_range(1, 255);
            else               b = $urandom;
            refModel(a, b, q, r, z);
            runVector($sformatf("rand%0d", n), a, b, q, r, z, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
